// File: rtl/sum_window_acc.sv
// Accumulates WINDOW samples from the adder stage and presents the window total on a held handshake.
// Define SUM_WINDOW_ACC_AVG_EN to present the rounded mean instead of the raw total.
module sum_window_acc #(
  parameter int DATA_W = 8,
  parameter int WINDOW = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clear,
  input  logic [DATA_W-1:0]                 in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [DATA_W+$clog2(WINDOW)-1:0]  out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [7:0]                        win_count
);

  localparam int LOG2W = $clog2(WINDOW);
  localparam int ACC_W = DATA_W + LOG2W;

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_sum, result;
  logic [LOG2W-1:0] cnt;
  logic             accept, last;

  // clear wins over a sample presented in the same cycle
  assign accept  = (state == ACC) && in_valid && !clear;
  assign last    = accept && (cnt == LOG2W'(WINDOW - 1));
  assign acc_sum = acc + ACC_W'(in_data);

`ifdef SUM_WINDOW_ACC_AVG_EN
  // cannot overflow: WINDOW*(2^DATA_W-1) + WINDOW/2 < 2^ACC_W
  logic [ACC_W-1:0] rnd;
  assign rnd    = acc_sum + ACC_W'(WINDOW / 2);
  assign result = rnd >> LOG2W;
`else
  assign result = acc_sum;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ACC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (last) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  // outputs decode the state flop directly, so both stay registered
  always_comb begin
    in_ready  = (state == ACC);
    out_valid = (state == HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      win_count <= '0;
    end else begin
      if (state == ACC && clear) begin
        acc <= '0;
        cnt <= '0;
      end else if (accept) begin
        if (last) begin
          out_data <= result;
          acc      <= '0;
          cnt      <= '0;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + 1'b1;
        end
      end
      if (state == HOLD && out_ready) win_count <= win_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_sum_window_acc.sv
// Randomized and directed bench for sum_window_acc against a queue-based window model.
// Honors SUM_WINDOW_ACC_AVG_EN to expect the rounded mean.
module tb_sum_window_acc;
  localparam int DATA_W = 8;
  localparam int WINDOW = 4;
  localparam int ACC_W  = DATA_W + $clog2(WINDOW);

  logic              clk = 1'b0;
  logic              reset, clear, in_valid, out_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, out_valid;
  logic [ACC_W-1:0]  out_data;
  logic [7:0]        win_count;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int unsigned q[$];
  bit          m_hold;
  int unsigned m_out;
  int unsigned m_wc;

  sum_window_acc #(.DATA_W(DATA_W), .WINDOW(WINDOW)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .win_count(win_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned window_result(input int unsigned s);
`ifdef SUM_WINDOW_ACC_AVG_EN
    return (s + WINDOW / 2) / WINDOW;
`else
    return s;
`endif
  endfunction

  task automatic model_edge();
    int unsigned s;
    if (reset) begin
      q.delete(); m_hold = 0; m_out = 0; m_wc = 0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 0;
        m_wc = (m_wc + 1) % 256;
      end
    end else if (clear) begin
      q.delete();
    end else if (in_valid) begin
      q.push_back(int'(in_data));
      if (q.size() == WINDOW) begin
        s = 0;
        foreach (q[i]) s += q[i];
        m_out = window_result(s);
        m_hold = 1;
        q.delete();
      end
    end
  endtask

  // drive, clock, update model, check all outputs on the falling edge
  task automatic step(input bit r, input bit c, input bit v, input int unsigned d, input bit ordy);
    reset = r; clear = c; in_valid = v; in_data = DATA_W'(d); out_ready = ordy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("in_ready",  in_ready,  !m_hold);
    chk("out_valid", out_valid, m_hold);
    chk("out_data",  out_data,  m_out);
    chk("win_count", win_count, m_wc);
  endtask

  initial begin
    int unsigned held, vcount;
    int unsigned seq[4];
    reset = 1; clear = 0; in_valid = 0; in_data = '0; out_ready = 0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);

    // 11,25,3,1 back to back
    seq = '{11, 25, 3, 1};
    foreach (seq[i]) step(0, 0, 1, seq[i], 1);
`ifdef SUM_WINDOW_ACC_AVG_EN
    chk("avg10", out_data, 10);
`else
    chk("raw40", out_data, 40);
`endif
    chk("raw40_valid", out_valid, 1);
    step(0, 0, 0, 0, 1);
    chk("wc1", win_count, 1);

    // full-scale window
    repeat (4) step(0, 0, 1, 255, 1);
`ifdef SUM_WINDOW_ACC_AVG_EN
    chk("avg255", out_data, 255);
`else
    chk("raw1020", out_data, 1020);
`endif
    step(0, 0, 0, 0, 1);

    // hold with backpressure; inputs during HOLD must be ignored
    repeat (4) step(0, 0, 1, $urandom_range(0, 255), 0);
    held = out_data;
    repeat (3) begin
      step(0, 0, 1, 99, 0);
      chk("hold_stable", out_data, held);
      chk("hold_in_ready", in_ready, 0);
    end
    step(0, 0, 1, 99, 1);
    chk("hold_wc", win_count, 3);
    chk("hold_release_ready", in_ready, 1);

    // clear drops partial window and same-cycle sample
    step(0, 0, 1, 7, 1);
    step(0, 0, 1, 9, 1);
    step(0, 1, 1, 50, 1);
    chk("clear_ready", in_ready, 1);
    repeat (4) step(0, 0, 1, 1, 1);
`ifdef SUM_WINDOW_ACC_AVG_EN
    chk("clear_avg1", out_data, 1);
`else
    chk("clear_raw4", out_data, 4);
`endif
    step(0, 0, 0, 0, 1);

    // clear during HOLD is ignored
    repeat (4) step(0, 0, 1, 3, 0);
    step(0, 1, 0, 0, 0);
    chk("hold_clear_valid", out_valid, 1);
    step(0, 0, 0, 0, 1);

    // reset during HOLD, then mid-window
    repeat (4) step(0, 0, 1, 20, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_hold_valid", out_valid, 0);
    chk("rst_hold_wc", win_count, 0);
    step(0, 0, 1, 40, 1);
    step(0, 0, 1, 40, 1);
    step(1, 0, 1, 40, 1);
    chk("rst_mid_ready", in_ready, 1);
    repeat (4) step(0, 0, 1, 2, 1);
`ifdef SUM_WINDOW_ACC_AVG_EN
    chk("rst_avg2", out_data, 2);
`else
    chk("rst_raw8", out_data, 8);
`endif
    step(1, 0, 0, 0, 0);

    // 256 windows at full rate: WINDOW+1 cycles each, win_count wraps
    vcount = 0;
    repeat (256 * (WINDOW + 1)) begin
      step(0, 0, 1, $urandom_range(0, 255), 1);
      if (out_valid) vcount++;
    end
    chk("wrap_windows", vcount, 256);
    chk("wrap_wc", win_count, 0);

    // random traffic
    repeat (3000) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) != 0), $urandom_range(0, 255),
           ($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sum_window_acc.md
# sum_window_acc

Downstream consumer of the registered 8-bit adder stage. Accepts one sum per cycle over a valid/ready handshake and accumulates a fixed window of WINDOW samples. It then presents the window total, or the rounded mean when configured, on a held output handshake. It also keeps a running count of emitted windows for the surrounding test and monitor logic.

## Interface
- DATA_W, 8, width of each incoming sum.
- WINDOW, 4, samples per window; power of two, 2..256.
- ACC_W, DATA_W + log2(WINDOW), derived localparam; width of accumulator and out_data. Not overridable.
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clk.
- clear  input  1  synchronous flush of the partial window; no effect on a pending result.
- in_data  input  DATA_W  sum from the adder stage.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a sample this cycle.
- out_data  output  ACC_W  window result.
- out_valid  output  1  out_data holds a completed window.
- out_ready  input  1  consumer accepts out_data.
- win_count  output  8  number of windows handed off; wraps 255 -> 0.

## Operation
- Two states: ACC and HOLD.
- ACC:
  - in_ready=1 and out_valid=0.
  - A sample is accepted when in_valid && in_ready at the clock edge.
  - On accept: acc <= acc + in_data (zero-extended to ACC_W); cnt <= cnt + 1.
  - When the accepted sample is number WINDOW of the window (cnt == WINDOW-1):
    - out_data <= final value (see Configuration).
    - acc <= 0; cnt <= 0; go to HOLD.
- HOLD:
  - in_ready=0 and out_valid=1.
  - out_data is stable until the handshake completes.
  - On out_ready: win_count <= win_count + 1 (mod 256); go to ACC.
- Arithmetic: ACC_W is sized so WINDOW * (2^DATA_W - 1) never overflows. No saturation logic is needed or present.
- clear in ACC:
  - acc <= 0 and cnt <= 0.
  - A sample presented in the same cycle is dropped: clear has priority and in_ready stays 1.
- clear in HOLD: ignored. The pending result still completes its handshake.
- reset has priority over everything. After reset:
  - State is ACC; acc, cnt and out_data are 0.
  - out_valid=0, in_ready=1, win_count=0.
- Reset mid-window or mid-HOLD discards all partial and pending data.

## Timing
- Accept of the final window sample at edge T -> out_valid=1 and out_data valid after edge T (visible in cycle T+1).
- HOLD lasts at least one cycle. Minimum period is WINDOW+1 cycles per window with out_ready tied high.
- in_ready is a pure function of state and does not depend on in_valid or out_ready (no combinational path input -> in_ready).
- out_valid and out_data are registered outputs.
- The upstream adder output is already registered, so in_data is consumed directly with no extra skid register.

## Configuration
- Macro: SUM_WINDOW_ACC_AVG_EN.
- Defined: out_data = (window_sum + WINDOW/2) >> log2(WINDOW), zero-extended to ACC_W. This is the rounded mean, always <= 2^DATA_W - 1. A rounding adder and shift are compiled in.
- Undefined: out_data = window_sum, the raw total. No rounding logic is present.
- Handshake, latency and win_count behaviour are identical in both builds.

## Test plan
- WINDOW=4, inputs 11, 25, 3, 1 back-to-back, out_ready=1:
  - Raw build: out_data=40 one cycle after the 4th accept.
  - AVG build: out_data=10.
  - win_count=1.
- Four inputs of 255: raw out_data=1020 (no overflow); AVG out_data=255.
- Hold out_ready=0 for 3 cycles after out_valid rises: out_data stays constant, in_ready=0, and inputs driven in that time are not absorbed. Raise out_ready -> win_count increments once and in_ready=1 the next cycle.
- Accept 7 and 9, assert clear for one cycle with in_valid=1 and in_data=50, then four inputs of 1: result is raw 4 / AVG 1. Neither the 7, the 9 nor the 50 contributes.
- Assert reset during HOLD and after two accepted samples: next cycle out_valid=0, in_ready=1, win_count=0. The following window of 2, 2, 2, 2 gives raw 8.
- Run 256 windows with out_ready=1: win_count wraps to 0. Each window occupies exactly WINDOW+1 cycles.
